apb_master_ctrl: RTL and testbench
==================================

# apb_master_ctrl

AHB-Lite slave to APB master control stage of the bridge. Accepts one AHB transfer at a time, decodes it to a one-hot APB slave select, and runs the APB SETUP/ACCESS sequence. It consumes the PRDATA/PREADY/PSLVERR that the downstream one-hot slave mux returns for the selected slave, then completes the AHB data phase with registered HRDATA/HRESP. Its PSEL vector is the select input of that mux.

## Interface
Parameters:
- DATA_WIDTH, 32: HWDATA/HRDATA/PWDATA/PRDATA width.
- TIMEOUT, 255: maximum ACCESS cycles waiting for PREADY; 0 disables the timeout.

Ports:
- HCLK  in  1  single clock for the block.
- HRESETn  in  1  reset, synchronous, active-low.
- HSEL  in  1  bridge selected.
- HADDR  in  32  AHB address.
- HTRANS  in  2  AHB transfer type; bit 1 set = NONSEQ/SEQ.
- HWRITE  in  1  AHB direction.
- HWDATA  in  DATA_WIDTH  AHB write data, valid in data phase.
- HREADY  in  1  bus-level ready.
- HREADYOUT  out  1  bridge ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  DATA_WIDTH  read data.
- PADDR  out  32  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PSEL  out  `NUM_APB_SLAVES  one-hot APB select (12 slaves).
- PENABLE  out  1  APB enable.
- PRDATA  in  DATA_WIDTH  muxed read data of selected slave.
- PREADY  in  1  muxed ready.
- PSLVERR  in  1  muxed error.

## Operation
- Transfer accepted when HSEL & HTRANS[1] & HREADY at a rising edge in IDLE, DONE or ERR2. HADDR and HWRITE captured into PADDR/PWRITE; slave index = HADDR[15:12].
- Index ≥ `NUM_APB_SLAVES: unmapped; go to ERR1, no APB access.
- HSEL with HTRANS IDLE/BUSY: ignored, OKAY, zero wait.
- States:
  - IDLE: HREADYOUT=1, HRESP=0, PSEL=0, PENABLE=0. Mapped accept -> LATCH.
  - LATCH: HREADYOUT=0; PWDATA<=HWDATA on writes (held otherwise). -> SETUP.
  - SETUP: PSEL[index]=1, PENABLE=0. -> ACCESS.
  - ACCESS: PSEL held, PENABLE=1, timeout counter increments.
    - PREADY & !PSLVERR -> DONE, HRDATA<=PRDATA on reads.
    - PREADY & PSLVERR -> ERR1.
    - Counter reaches TIMEOUT without PREADY -> ERR1.
  - DONE: HREADYOUT=1, HRESP=0, PSEL=0, PENABLE=0. -> LATCH on mapped accept, ERR1 on unmapped accept, else IDLE.
  - ERR1: HREADYOUT=0, HRESP=1, PSEL=0. -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Same exits as DONE.
- HRDATA holds its last value except when updated by a read completion. Writes and errors leave HRDATA unchanged.
- Timeout counter clears on entry to SETUP. Width is ceil(log2(TIMEOUT+1)).
- PADDR, PWRITE and PWDATA remain stable from SETUP through the last ACCESS cycle.

## Timing
- All outputs are registered. PREADY/PSLVERR/PRDATA sampled only in ACCESS.
- Reset (HRESETn low at an edge) applies next cycle, including mid-transfer:
  - state=IDLE, HREADYOUT=1, HRESP=0, PSEL=0, PENABLE=0;
  - PADDR=0, PWRITE=0, PWDATA=0, HRDATA=0, counter=0.
  - Aborted APB access: PSEL/PENABLE drop with no further handshake.
- Accept at edge T0 gives LATCH in T1, SETUP in T2 and ACCESS in T3.
  - PREADY high in T3 gives DONE in T4.
  - Zero-wait slave: 3 AHB wait states. Each PREADY-low ACCESS cycle adds one.
- Error: ERR1 one cycle (HREADYOUT=0, HRESP=1), then ERR2 one cycle (HREADYOUT=1, HRESP=1).
  - Unmapped accept at T0: ERR1 in T1, ERR2 in T2.
- Back-to-back: an accept in DONE/ERR2 enters LATCH (or ERR1) next cycle with no IDLE gap.
- Timeout N (N>0): with PREADY low, the last ACCESS cycle is the Nth; ERR1 follows. A PREADY that arrives in the Nth cycle takes priority over the timeout.

## Test plan
- Write 0xA5A5_0001 to HADDR 0x0000_3004, PREADY tied 1:
  - PSEL=12'h008, PWDATA=0xA5A5_0001, PADDR=0x3004, PWRITE=1;
  - PENABLE high exactly one cycle; HREADYOUT low 3 cycles, then high with HRESP=0.
- Read HADDR 0x0000_B000, PRDATA=0xDEAD_BEEF, PREADY low 2 ACCESS cycles:
  - PSEL=12'h800; HREADYOUT low 5 cycles; HRDATA=0xDEAD_BEEF in DONE.
- Read HADDR 0x0000_C000 (index 12): PSEL stays 0; ERR1 then ERR2 (HRESP=1, HREADYOUT 0 then 1).
- PSLVERR=1 with PREADY=1 on a slave-0 write: ERR1/ERR2 response, PSEL=0 during ERR1, HRDATA unchanged.
- TIMEOUT=4, PREADY held 0:
  - PENABLE high 4 cycles, then ERR1/ERR2;
  - a following read to slave 1 completes normally.
- Reset mid-ACCESS: HRESETn low one edge → next cycle PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0; a new transfer after release completes OKAY.

Source files
------------

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl
//   AHB-Lite slave to APB master control stage of the bridge. It accepts one
//   AHB transfer at a time and decodes HADDR[15:12] into a one-hot APB select.
//   It then runs the APB SETUP/ACCESS handshake and finishes the AHB data
//   phase with a registered HRDATA/HRESP. All outputs are registered.
//
// Ports
//   HCLK, HRESETn        clock, synchronous active-low reset
//   HSEL, HADDR, HTRANS  AHB address phase (HTRANS[1] = NONSEQ/SEQ)
//   HWRITE, HWDATA       AHB direction / write data (data phase)
//   HREADY               bus-level ready
//   HREADYOUT, HRESP     bridge ready / response (1 = ERROR)
//   HRDATA               read data, updated only by a successful read
//   PADDR, PWRITE        APB address / direction
//   PWDATA               APB write data
//   PSEL, PENABLE        one-hot APB select (drives the slave mux) / enable
//   PRDATA, PREADY       muxed slave read data / ready
//   PSLVERR              muxed slave error

`ifndef NUM_APB_SLAVES
`define NUM_APB_SLAVES 12
`endif

module apb_master_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       HSEL,
  input  logic [31:0]                HADDR,
  input  logic [1:0]                 HTRANS,
  input  logic                       HWRITE,
  input  logic [DATA_WIDTH-1:0]      HWDATA,
  input  logic                       HREADY,
  output logic                       HREADYOUT,
  output logic                       HRESP,
  output logic [DATA_WIDTH-1:0]      HRDATA,
  output logic [31:0]                PADDR,
  output logic                       PWRITE,
  output logic [DATA_WIDTH-1:0]      PWDATA,
  output logic [`NUM_APB_SLAVES-1:0] PSEL,
  output logic                       PENABLE,
  input  logic [DATA_WIDTH-1:0]      PRDATA,
  input  logic                       PREADY,
  input  logic                       PSLVERR
);

  localparam int unsigned NS = `NUM_APB_SLAVES;
  // A zero TIMEOUT still needs a 1-bit counter to keep the logic well formed.
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The counter holds k-1 during the k-th ACCESS cycle, so the last cycle
  // allowed without PREADY is the one where it equals TIMEOUT-1.
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SETUP,
    S_ACCESS,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t        st, nxt;
  logic          accept;
  logic          mapped;
  logic          take;
  logic [3:0]    sel_idx;
  logic [CW-1:0] cnt;
  logic [NS-1:0] sel_onehot;
  logic          unused_htrans0;

  assign unused_htrans0 = HTRANS[0];

  assign sel_onehot = {{(NS-1){1'b0}}, 1'b1} << sel_idx;

  always_comb begin
    nxt    = st;
    accept = HSEL & HTRANS[1] & HREADY;
    mapped = (32'(HADDR[15:12]) < 32'(NS));
    take   = 1'b0;
    case (st)
      S_IDLE, S_DONE, S_ERR2: begin
        if (accept) begin
          take = 1'b1;
          nxt  = mapped ? S_LATCH : S_ERR1;
        end else begin
          nxt = S_IDLE;
        end
      end
      S_LATCH: nxt = S_SETUP;
      S_SETUP: nxt = S_ACCESS;
      S_ACCESS: begin
        // PREADY wins over the timeout in the final allowed cycle.
        if (PREADY)
          nxt = PSLVERR ? S_ERR1 : S_DONE;
        else if ((TIMEOUT != 0) && (cnt == TO_LAST))
          nxt = S_ERR1;
      end
      S_ERR1:  nxt = S_ERR2;
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that each one is a flop.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      st        <= S_IDLE;
      sel_idx   <= '0;
      cnt       <= '0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      HRDATA    <= '0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
    end else begin
      st <= nxt;

      if (take) begin
        PADDR   <= HADDR;
        PWRITE  <= HWRITE;
        sel_idx <= HADDR[15:12];
      end

      if ((st == S_LATCH) && PWRITE)
        PWDATA <= HWDATA;

      if (nxt == S_SETUP)
        cnt <= '0;
      else if (st == S_ACCESS)
        cnt <= cnt + CW'(1);

      if ((st == S_ACCESS) && PREADY && !PSLVERR && !PWRITE)
        HRDATA <= PRDATA;

      HREADYOUT <= (nxt == S_IDLE) || (nxt == S_DONE) || (nxt == S_ERR2);
      HRESP     <= (nxt == S_ERR1) || (nxt == S_ERR2);
      PSEL      <= ((nxt == S_SETUP) || (nxt == S_ACCESS)) ? sel_onehot : '0;
      PENABLE   <= (nxt == S_ACCESS);
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
module tb_apb_master_ctrl;

  logic        HCLK;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [11:0] PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int checks   = 0;
  int failures = 0;

  apb_master_ctrl #(.DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one AHB transfer from a ready state and follows it until
  // HREADYOUT returns high. The slave keeps PREADY low for n_low ACCESS
  // cycles, then raises it (with PSLVERR = slverr).
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input int n_low, input logic slverr, input logic [31:0] rdata,
                      output int waits, output int enables,
                      output logic [11:0] psel_or, output logic [11:0] psel_last,
                      output logic resp_last);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HREADY = 1'b1;
    cyc();
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
    waits = 0; enables = 0; psel_or = '0; psel_last = '0; resp_last = 1'b0;
    for (int i = 0; i < 100 && HREADYOUT !== 1'b1; i++) begin
      waits++;
      psel_or   |= PSEL;
      psel_last = PSEL;
      resp_last = HRESP;
      if (PENABLE === 1'b1) begin
        PREADY  = (enables >= n_low);
        PSLVERR = slverr && PREADY;
        PRDATA  = rdata;
        enables++;
      end else begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
      end
      cyc();
    end
    PREADY = 1'b0; PSLVERR = 1'b0;
  endtask

  int          w, e;
  logic [11:0] por, plast;
  logic        rlast;

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HWDATA = '0; HREADY = 1'b1; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    cyc(); cyc();
    HRESETn = 1'b1;
    chk("rst_hreadyout", HREADYOUT, 1);
    chk("rst_hresp",     HRESP, 0);
    chk("rst_psel",      PSEL, 0);
    chk("rst_penable",   PENABLE, 0);
    chk("rst_paddr",     PADDR, 0);
    chk("rst_hrdata",    HRDATA, 0);

    // HSEL with an IDLE transfer type is ignored
    HSEL = 1'b1; HTRANS = 2'b00; HADDR = 32'h0000_3000;
    cyc();
    HSEL = 1'b0;
    chk("idle_hreadyout", HREADYOUT, 1);
    chk("idle_psel",      PSEL, 0);
    chk("idle_hresp",     HRESP, 0);

    // Write, zero-wait slave
    xfer(32'h0000_3004, 1'b1, 32'hA5A5_0001, 0, 1'b0, 32'h0, w, e, por, plast, rlast);
    chk("wr_waits",   w, 3);
    chk("wr_enables", e, 1);
    chk("wr_psel",    por, 12'h008);
    chk("wr_hresp",   HRESP, 0);
    chk("wr_paddr",   PADDR, 32'h0000_3004);
    chk("wr_pwrite",  PWRITE, 1);
    chk("wr_pwdata",  PWDATA, 32'hA5A5_0001);

    // Read slave 11, two PREADY-low cycles (back-to-back from DONE)
    xfer(32'h0000_B000, 1'b0, 32'h0, 2, 1'b0, 32'hDEAD_BEEF, w, e, por, plast, rlast);
    chk("rd11_waits",  w, 5);
    chk("rd11_psel",   por, 12'h800);
    chk("rd11_hresp",  HRESP, 0);
    chk("rd11_hrdata", HRDATA, 32'hDEAD_BEEF);

    // Unmapped index 12
    xfer(32'h0000_C000, 1'b0, 32'h0, 0, 1'b0, 32'h1111_1111, w, e, por, plast, rlast);
    chk("unm_waits",   w, 1);
    chk("unm_psel",    por, 0);
    chk("unm_err1",    rlast, 1);
    chk("unm_err2",    HRESP, 1);
    chk("unm_hrdata",  HRDATA, 32'hDEAD_BEEF);

    // Slave error on a slave-0 write
    xfer(32'h0000_0010, 1'b1, 32'h5555_AAAA, 0, 1'b1, 32'h2222_2222, w, e, por, plast, rlast);
    chk("slverr_waits",  w, 4);
    chk("slverr_psel",   por, 12'h001);
    chk("slverr_pselE1", plast, 0);
    chk("slverr_err1",   rlast, 1);
    chk("slverr_err2",   HRESP, 1);
    chk("slverr_hrdata", HRDATA, 32'hDEAD_BEEF);

    // Timeout: PREADY never arrives, TIMEOUT=4
    xfer(32'h0000_4000, 1'b0, 32'h0, 100, 1'b0, 32'h3333_3333, w, e, por, plast, rlast);
    chk("to_enables", e, 4);
    chk("to_waits",   w, 7);
    chk("to_err1",    rlast, 1);
    chk("to_err2",    HRESP, 1);
    chk("to_hrdata",  HRDATA, 32'hDEAD_BEEF);

    // Following read to slave 1 completes normally
    xfer(32'h0000_1008, 1'b0, 32'h0, 0, 1'b0, 32'hCAFE_0001, w, e, por, plast, rlast);
    chk("rd1_waits",  w, 3);
    chk("rd1_psel",   por, 12'h002);
    chk("rd1_hresp",  HRESP, 0);
    chk("rd1_hrdata", HRDATA, 32'hCAFE_0001);

    // PREADY in the 4th (last allowed) ACCESS cycle beats the timeout
    xfer(32'h0000_2000, 1'b0, 32'h0, 3, 1'b0, 32'h1234_5678, w, e, por, plast, rlast);
    chk("edge_enables", e, 4);
    chk("edge_hresp",   HRESP, 0);
    chk("edge_hrdata",  HRDATA, 32'h1234_5678);

    // Reset in the middle of ACCESS
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_5000; HWRITE = 1'b1;
    cyc();
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h7777_8888;
    cyc();
    cyc();
    chk("mid_penable", PENABLE, 1);
    chk("mid_psel",    PSEL, 12'h020);
    HRESETn = 1'b0;
    cyc();
    HRESETn = 1'b1;
    chk("mrst_psel",      PSEL, 0);
    chk("mrst_penable",   PENABLE, 0);
    chk("mrst_hreadyout", HREADYOUT, 1);
    chk("mrst_hresp",     HRESP, 0);
    chk("mrst_pwdata",    PWDATA, 0);
    chk("mrst_hrdata",    HRDATA, 0);

    xfer(32'h0000_3000, 1'b0, 32'h0, 1, 1'b0, 32'h0BAD_F00D, w, e, por, plast, rlast);
    chk("post_waits",  w, 4);
    chk("post_hresp",  HRESP, 0);
    chk("post_hrdata", HRDATA, 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
